// File: rtl/minicpu_sequencer.sv
// minicpu_sequencer
//   Program sequencer for the 8-bit mini CPU datapath. Holds 2**AW program
//   words of 12 bits ([11:8] opcode, [7:0] data) and issues them to the CPU's
//   In bus one at a time. After each word it captures cpu_Out and cpu_Overflow.
//   A run stops on a HALT_OP word (which is never issued), after the last
//   memory address (there is no wrap), or on overflow when STOP_ON_OVF=1.
//
//   Optional feature, enabled by defining MINICPU_SEQ_STEP_EN:
//     This adds input `step`. After each capture that does not end the run,
//     the FSM waits in PAUSE until step=1 and then fetches the next word.
//
// Ports
//   Clock        in   1   rising-edge clock
//   CLR          in   1   asynchronous active-high reset
//   prog_we      in   1   program write strobe (honoured only in IDLE)
//   prog_addr    in   AW  program write address
//   prog_data    in   12  program word
//   start        in   1   starts a run from address 0 (honoured only in IDLE)
//   step         in   1   leaves PAUSE (only with MINICPU_SEQ_STEP_EN)
//   cpu_In       out  12  word on the CPU In bus; NOP_WORD unless issuing
//   cpu_Out      in   8   CPU result
//   cpu_Overflow in   1   CPU overflow flag
//   busy         out  1   run in progress (FETCH/ISSUE/CAPTURE/PAUSE)
//   done         out  1   one-cycle pulse when a run ends
//   ovf_halt     out  1   sticky overflow seen during the run
//   result       out  8   cpu_Out captured at the last capture
//   pc           out  AW  address being fetched or issued
module minicpu_sequencer #(
  parameter int unsigned AW          = 4,
  parameter int unsigned SETTLE      = 1,
  parameter logic [3:0]  HALT_OP     = 4'hF,
  parameter logic [11:0] NOP_WORD    = 12'hF00,
  parameter logic        STOP_ON_OVF = 1'b1
) (
  input  logic          Clock,
  input  logic          CLR,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [11:0]   prog_data,
  input  logic          start,
`ifdef MINICPU_SEQ_STEP_EN
  input  logic          step,
`endif
  output logic [11:0]   cpu_In,
  input  logic [7:0]    cpu_Out,
  input  logic          cpu_Overflow,
  output logic          busy,
  output logic          done,
  output logic          ovf_halt,
  output logic [7:0]    result,
  output logic [AW-1:0] pc
);

  localparam int unsigned DEPTH     = 2**AW;
  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_CAPTURE,
`ifdef MINICPU_SEQ_STEP_EN
    S_PAUSE,
`endif
    S_DONE
  } state_t;

  state_t        r_state;
  logic [11:0]   r_mem [DEPTH];
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_result;
  logic          r_ovf_halt;
  logic          r_busy;
  logic          r_done;
  logic [11:0]   r_cpu_in;

  logic [11:0]   w_word;
  logic          w_mem_we;

  assign w_word   = r_mem[r_pc];
  assign w_mem_we = prog_we && (r_state == S_IDLE);

  // Program memory is deliberately outside the reset domain: CLR keeps it.
  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // The cpu_In register doubles as the instruction register. It is loaded
  // from memory at the end of FETCH and held for the whole ISSUE phase.
  always_ff @(posedge Clock or posedge CLR) begin
    if (CLR) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_result   <= '0;
      r_ovf_halt <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cpu_in   <= NOP_WORD;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pc       <= '0;
            r_ovf_halt <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_word[11:8] == HALT_OP) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cpu_in <= w_word;
            r_cnt    <= SETTLE_M1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_cnt == '0) begin
            r_cpu_in <= NOP_WORD;
            r_state  <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          r_result <= cpu_Out;
          if (cpu_Overflow) begin
            r_ovf_halt <= 1'b1;
          end
          if ((cpu_Overflow && STOP_ON_OVF) || (r_pc == '1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_pc <= r_pc + 1'b1;
`ifdef MINICPU_SEQ_STEP_EN
            r_state <= S_PAUSE;
`else
            r_state <= S_FETCH;
`endif
          end
        end
`ifdef MINICPU_SEQ_STEP_EN
        S_PAUSE: begin
          if (step) begin
            r_state <= S_FETCH;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_cpu_in <= NOP_WORD;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_In   = r_cpu_in;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ovf_halt = r_ovf_halt;
  assign result   = r_result;
  assign pc       = r_pc;

endmodule

// File: tb/tb_minicpu_sequencer.sv
module tb_minicpu_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam logic [11:0] NOP    = 12'hF00;

  logic        Clock = 1'b0;
  logic        CLR = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic        start = 1'b0;
  logic [11:0] cpu_In;
  logic [7:0]  cpu_Out = '0;
  logic        cpu_Overflow = 1'b0;
  logic        busy, done, ovf_halt;
  logic [7:0]  result;
  logic [3:0]  pc;
`ifdef MINICPU_SEQ_STEP_EN
  logic        step = 1'b1;
`endif

  minicpu_sequencer #(.AW(4), .SETTLE(SETTLE), .HALT_OP(4'hF), .NOP_WORD(NOP),
                      .STOP_ON_OVF(1'b1)) dut (
    .Clock(Clock), .CLR(CLR), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start),
`ifdef MINICPU_SEQ_STEP_EN
    .step(step),
`endif
    .cpu_In(cpu_In), .cpu_Out(cpu_Out), .cpu_Overflow(cpu_Overflow),
    .busy(busy), .done(done), .ovf_halt(ovf_halt), .result(result), .pc(pc)
  );

  always #5 Clock = ~Clock;

  // Stub CPU: Out = data of the last word seen on In; opcode E overflows.
  always @(posedge Clock) begin
    if (cpu_In !== NOP) begin
      cpu_Out      <= cpu_In[7:0];
      cpu_Overflow <= (cpu_In[11:8] == 4'hE);
    end
  end

  typedef struct { logic [11:0] w; logic [3:0] a; } word_t;
  typedef struct { logic [7:0] res; logic ovf; logic [3:0] a; int lat; } end_t;
  word_t q_word[$];
  end_t  q_end[$];
  word_t we;
  end_t  ee;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [11:0] m_prog [16];
  logic [7:0]  m_result = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge Clock) cyc++;

  // Monitor: pops expectations whenever the DUT issues a word or ends a run.
  logic [11:0] prev_in = 12'hF00;
  int  hold = 0, t_start = 0;
  bit  want_busy = 1'b0, saw_done = 1'b0;
  always @(negedge Clock) begin
    if (mon_en) begin
      if (cpu_In !== NOP) begin
        if (prev_in === NOP) begin
          chk("issue_expected", 32'(q_word.size() > 0), 32'd1);
          if (q_word.size() > 0) begin
            we = q_word.pop_front();
            chk("issue_word", 32'(cpu_In), 32'(we.w));
            chk("issue_pc", 32'(pc), 32'(we.a));
          end
          hold = 1;
        end else hold++;
      end else if (prev_in !== NOP) begin
        chk("settle_len", 32'(hold), 32'(SETTLE));
      end
      prev_in = cpu_In;
      if (saw_done) begin
        chk("done_one_cycle", 32'(done), 32'd0);
        saw_done = 1'b0;
      end
      if (want_busy) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        want_busy = 1'b0;
      end
      if (start && !busy && !done) begin
        t_start   = cyc;
        want_busy = 1'b1;
      end
      if (done) begin
        saw_done = 1'b1;
        chk("done_expected", 32'(q_end.size() > 0), 32'd1);
        if (q_end.size() > 0) begin
          ee = q_end.pop_front();
          chk("result", 32'(result), 32'(ee.res));
          chk("ovf_halt", 32'(ovf_halt), 32'(ee.ovf));
          chk("final_pc", 32'(pc), 32'(ee.a));
          chk("busy_in_done", 32'(busy), 32'd0);
          if (ee.lat >= 0) chk("latency", 32'(cyc - t_start), 32'(ee.lat));
        end
      end
    end
  end

  // Reference model: walk the program by its rules and predict the run.
  task automatic model_run(input bit no_lat);
    int n = 0, last = 0;
    bit halted = 1'b0;
    end_t e;
    for (int i = 0; i < 16; i++) begin
      last = i;
      if (m_prog[i][11:8] == 4'hF) begin halted = 1'b1; break; end
      q_word.push_back('{w: m_prog[i], a: 4'(i)});
      n++;
      m_result = m_prog[i][7:0];
      if (m_prog[i][11:8] == 4'hE) break;
    end
    e.res = m_result;
    e.ovf = (m_prog[last][11:8] == 4'hE);
    e.a   = 4'(last);
    e.lat = n * (2 + int'(SETTLE)) + (halted ? 2 : 1);
`ifdef MINICPU_SEQ_STEP_EN
    e.lat = e.lat + (halted ? n : n - 1);
`endif
    if (no_lat) e.lat = -1;
    q_end.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic load(input bit with_start);
    for (int a = 0; a < 16; a++) begin
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = m_prog[a];
      if (a == 15 && with_start) start = 1'b1;
      tick();
    end
    prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge Clock);
      if (done) break;
    end
    chk("done_within_budget", 32'(k < 3000), 32'd1);
    tick();
  endtask

  task automatic run(input bit concurrent);
    model_run(1'b0);
    load(concurrent);
    if (!concurrent) start_run();
    wait_done();
  endtask

  task automatic gen(input bit allow_stop);
    for (int i = 0; i < 16; i++) begin
      int r;
      logic [3:0] op;
      r = int'($urandom_range(0, 19));
      if (allow_stop && r == 0) op = 4'hF;
      else if (allow_stop && r == 1) op = 4'hE;
      else op = 4'($urandom_range(0, 13));
      m_prog[i] = {op, 8'($urandom_range(0, 255))};
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < 16; i++) m_prog[i] = 12'h0FF;
    m_prog[0] = 12'h005; m_prog[1] = 12'h003; m_prog[2] = 12'hF00;
  endtask

  initial begin
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_in", 32'(cpu_In), 32'hF00);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ovf", 32'(ovf_halt), 32'd0);
    CLR = 1'b0;
    tick();
    mon_en = 1'b1;

    // Basic program: two words then HALT.
    set_basic();
    run(1'b0);

    // CLR while word 1 is on the bus.
    begin
      int k;
      mon_en = 1'b0;
      start_run();
      for (k = 0; k < 200; k++) begin
        @(negedge Clock);
        if (cpu_In === 12'h003) break;
      end
      chk("reach_issue", 32'(k < 200), 32'd1);
      CLR = 1'b1;
      #1;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_cpu_in", 32'(cpu_In), 32'hF00);
      chk("clr_result", 32'(result), 32'd0);
      chk("clr_pc", 32'(pc), 32'd0);
      chk("clr_done", 32'(done), 32'd0);
      #2;
      CLR = 1'b0;
      tick();
      q_word.delete(); q_end.delete();
      prev_in = NOP; want_busy = 1'b0; saw_done = 1'b0; m_result = '0;
      mon_en = 1'b1;
      // Memory survives CLR: re-run without reloading.
      model_run(1'b0);
      start_run();
      wait_done();
    end

    // Overflow on word 1 stops the run; word 2 must never appear.
    for (int i = 0; i < 16; i++) m_prog[i] = 12'h0AA;
    m_prog[0] = 12'h011; m_prog[1] = 12'hE22; m_prog[2] = 12'h033;
    run(1'b0);
    set_basic();
    run(1'b0);

    // Full memory, no HALT, start issued together with the last write.
    gen(1'b0);
    run(1'b1);

    // prog_we/start while busy are ignored; the same program re-runs.
    model_run(1'b0);
    start_run();
    tick(6);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 12'hF00; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_done();
    model_run(1'b0);
    start_run();
    wait_done();

    // Random programs with occasional HALT and overflow words.
    for (int r = 0; r < 12; r++) begin
      gen(1'b1);
      run(r[0]);
    end

`ifdef MINICPU_SEQ_STEP_EN
    // Hold in PAUSE after word 0, then release with step.
    for (int i = 0; i < 16; i++) m_prog[i] = 12'h0FF;
    m_prog[0] = 12'h001; m_prog[1] = 12'h002; m_prog[2] = 12'hF00;
    step = 1'b0;
    model_run(1'b1);
    load(1'b0);
    start_run();
    tick(30);
    chk("pause_busy", 32'(busy), 32'd1);
    chk("pause_cpu_in", 32'(cpu_In), 32'hF00);
    chk("pause_pc", 32'(pc), 32'd1);
    chk("pause_pending", 32'(q_word.size()), 32'd1);
    step = 1'b1;
    wait_done();
`endif

    tick(3);
    chk("queues_drained", 32'(q_word.size() + q_end.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
